seq_pp_multiplier: RTL and testbench



---
 rtl/seq_pp_multiplier_if.sv | 24 ++
 rtl/seq_pp_multiplier.sv | 99 +++++++++
 tb/tb_seq_pp_multiplier.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pp_multiplier_if.sv
// Operand/result handshake bundle for seq_pp_multiplier.
// slave is the multiplier side, master is the producer/consumer side.
interface seq_pp_multiplier_if #(
    parameter int WIDTH = 16
);
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH-1:0]   input1_i;
    logic [WIDTH-1:0]   input2_i;
    logic               valid_o;
    logic               ready_i;
    logic [2*WIDTH-1:0] result_o;
    logic               busy_o;

    modport slave (
        input  valid_i, input1_i, input2_i, ready_i,
        output ready_o, valid_o, result_o, busy_o
    );

    modport master (
        output valid_i, input1_i, input2_i, ready_i,
        input  ready_o, valid_o, result_o, busy_o
    );
endinterface

// File: rtl/seq_pp_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one partial-product row per cycle.
// Define APPROX_TRUNC_EN to drop result columns below TRUNC_BITS.
module seq_pp_multiplier #(
    parameter int WIDTH      = 16,
    parameter int TRUNC_BITS = 8
) (
    input logic               clk_i,
    input logic               rst_n_i,
    seq_pp_multiplier_if.slave bus
);
    localparam int P  = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] KLAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 64 || TRUNC_BITS < 0 || TRUNC_BITS >= P) begin : g_bad_param
        $error("seq_pp_multiplier: WIDTH or TRUNC_BITS out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [P-1:0]   acc_q, acc_d;
    logic [CW-1:0]  k_q, k_d;
    logic [P-1:0]   row;

`ifdef APPROX_TRUNC_EN
    localparam logic [P-1:0] TMASK = ~((P'(1) << TRUNC_BITS) - P'(1));
`endif

    // Current shifted partial-product row, masked in the truncated build
    always_comb begin
        row = P'(a_q & {WIDTH{b_q[k_q]}}) << k_q;
`ifdef APPROX_TRUNC_EN
        row = row & TMASK;
`endif
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    a_d     = bus.input1_i;
                    b_d     = bus.input2_i;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + row;
                k_d   = k_q + CW'(1);
                if (k_q == KLAST) begin
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
        end
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.busy_o   = (state_q == RUN);
    assign bus.valid_o  = (state_q == DONE);
    assign bus.result_o = acc_q;
endmodule

// File: tb/tb_seq_pp_multiplier.sv
// Randomised and directed bench for seq_pp_multiplier.
// A transaction-level model tracks expected handshake state and products.
module tb_seq_pp_multiplier;
    localparam int W = 16;
    localparam int P = 2 * W;
    localparam int T = 4;

    logic clk;
    logic rst_n;

    seq_pp_multiplier_if #(.WIDTH(W)) bus ();

    seq_pp_multiplier #(
        .WIDTH     (W),
        .TRUNC_BITS(T)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [P-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] s;
        s = 0;
`ifdef APPROX_TRUNC_EN
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (a[i] && b[j] && (i + j) >= T)
                    s = s + (64'd1 << (i + j));
`else
        s = 64'(a) * 64'(b);
`endif
        return s[P-1:0];
    endfunction

    bit          m_ready;
    bit          m_busy;
    bit          m_valid;
    int          run_left;
    logic [P-1:0] m_prod;
    logic [P-1:0] m_result;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready  = 1'b1;
            m_busy   = 1'b0;
            m_valid  = 1'b0;
            run_left = 0;
            m_result = '0;
        end else if (m_ready) begin
            if (bus.valid_i) begin
                m_ready  = 1'b0;
                m_busy   = 1'b1;
                run_left = W;
                m_prod   = ref_mul(bus.input1_i, bus.input2_i);
            end
        end else if (m_busy) begin
            run_left--;
            if (run_left == 0) begin
                m_busy   = 1'b0;
                m_valid  = 1'b1;
                m_result = m_prod;
            end
        end else if (m_valid && bus.ready_i) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_o", 64'(bus.ready_o), 64'(m_ready));
            chk("busy_o", 64'(bus.busy_o), 64'(m_busy));
            chk("valid_o", 64'(bus.valid_o), 64'(m_valid));
            if (!m_busy)
                chk("result_o", 64'(bus.result_o), 64'(m_result));
        end
    end

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [P-1:0] lit, input bit use_lit,
                          input int stall, input bit scramble);
        int n;
        logic [P-1:0] exp;
        exp = ref_mul(a, b);
        if (use_lit) chk("model_lit", 64'(exp), 64'(lit));
        @(negedge clk);
        bus.input1_i = a;
        bus.input2_i = b;
        bus.valid_i  = 1'b1;
        bus.ready_i  = 1'b0;
        n = 0;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("accept");
        @(posedge clk);
        #1;
        if (!scramble) bus.valid_i = 1'b0;
        n = 0;
        while (!bus.valid_o && n < 200) begin
            if (scramble) begin
                bus.input1_i = W'($urandom);
                bus.input2_i = W'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(W));
        chk("product", 64'(bus.result_o), 64'(exp));
        if (use_lit) chk("product_lit", 64'(bus.result_o), 64'(lit));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(bus.valid_o), 64'd1);
            chk("stall_ready", 64'(bus.ready_o), 64'd0);
            chk("stall_result", 64'(bus.result_o), 64'(exp));
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        chk("handoff_valid", 64'(bus.valid_o), 64'd0);
        chk("handoff_ready", 64'(bus.ready_o), 64'd1);
        chk("handoff_result", 64'(bus.result_o), 64'(exp));
    endtask

`ifdef APPROX_TRUNC_EN
    localparam logic [P-1:0] L_3X5  = 32'd0;
    localparam logic [P-1:0] L_FF   = 32'hFFFDFFD0;
    localparam logic [P-1:0] L_7X9  = 32'd48;
`else
    localparam logic [P-1:0] L_3X5  = 32'd15;
    localparam logic [P-1:0] L_FF   = 32'hFFFE0001;
    localparam logic [P-1:0] L_7X9  = 32'd63;
`endif

    initial begin
        int n;
        tests        = 0;
        fails        = 0;
        bus.valid_i  = 1'b0;
        bus.ready_i  = 1'b0;
        bus.input1_i = '0;
        bus.input2_i = '0;
        rst_n        = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_result", 64'(bus.result_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd3, 16'd5, L_3X5, 1'b1, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, L_FF, 1'b1, 0, 1'b0);
        run_op(16'h0000, 16'hABCD, 32'd0, 1'b1, 1, 1'b0);
        run_op(16'h1234, 16'h0010, 32'h12340, 1'b1, 20, 1'b0);

        run_op(16'h00A5, 16'h0101, 32'd0, 1'b0, 0, 1'b1);
        @(posedge clk);
        #1;
        chk("reaccept_busy", 64'(bus.busy_o), 64'd1);
        chk("reaccept_ready", 64'(bus.ready_o), 64'd0);
        bus.valid_i = 1'b0;
        n = 0;
        while (!bus.valid_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) timeout("drain");
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;

        @(negedge clk);
        bus.input1_i = 16'h5555;
        bus.input2_i = 16'h3333;
        bus.valid_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.valid_o), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy_o), 64'd0);
        chk("mid_rst_result", 64'(bus.result_o), 64'd0);
        chk("mid_rst_ready", 64'(bus.ready_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd7, 16'd9, L_7X9, 1'b1, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 32'd0, 1'b0,
                   int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
